// File: rtl/dbg_uart_pkg.sv
// Shared types, ASCII constants and the nibble-to-hex-character helper.
package dbg_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h37;

  // 0..9 -> '0'..'9', 10..15 -> 'A'..'F'
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    else           return ASCII_A_OFS + {4'h0, n};
  endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Generic synchronous FIFO; head word is presented combinationally on rdata.
module dbg_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees a slot this cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer/count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dbg_uart_tx.sv
// Debug word change detector + FIFO + hex/LF 8N1 UART serializer.
module dbg_uart_tx
  import dbg_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dbg_in,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] last_q, last_d, word_q, word_d, baud_q, baud_d;
  logic [7:0]  byte_q, byte_d;
  logic [2:0]  char_idx_q, char_idx_d, bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;

  logic             chg, fifo_pop, fifo_full, fifo_empty, baud_end;
  logic [15:0]      fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       nib;

  assign chg      = (dbg_in != last_q);
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign baud_end = (baud_q == BAUD_LAST);

  dbg_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (chg),
    .pop   (fifo_pop),
    .wdata (dbg_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Change tracking; a dropped push still updates last and latches overflow
  always_comb begin
    last_d = last_q;
    ovf_d  = ovf_q;
    if (chg) begin
      last_d = dbg_in;
      if (fifo_full && !fifo_pop) ovf_d = 1'b1;
    end
  end

  // Select the nibble for the current character, MS nibble first
  always_comb begin
    case (char_idx_q[1:0])
      2'd0:    nib = word_q[15:12];
      2'd1:    nib = word_q[11:8];
      2'd2:    nib = word_q[7:4];
      default: nib = word_q[3:0];
    endcase
  end

  // Transmit FSM; tx is derived from the current state and registered
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_d     = byte_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    tx_d       = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          word_d     = fifo_rdata;
          char_idx_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        byte_d  = (char_idx_q == 3'd4) ? ASCII_LF : nib2ascii(nib);
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else baud_d = baud_q + 16'd1;
      end
      DATA: begin
        tx_d = byte_q[bit_idx_q];
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else baud_d = baud_q + 16'd1;
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (char_idx_q == 3'd4) state_d = IDLE;
          else begin
            char_idx_d = char_idx_q + 3'd1;
            state_d    = LOAD;
          end
        end else baud_d = baud_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_q != IDLE) || (fifo_count != '0);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      char_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      char_idx_q <= char_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Directed bench for dbg_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_dbg_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dbg_in;
  logic        tx, busy, overflow;

  int n_chk = 0, n_pass = 0, cyc = 0, frame_err = 0;
  logic [7:0]  rx_q[$];
  int          start_q[$];
  logic [39:0] exp_w[8];

  typedef struct { logic [15:0] word; logic [39:0] str; } vec_t;
  vec_t vecs[5];

  dbg_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .dbg_in(dbg_in),
    .tx(tx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver: samples each bit mid-way on the falling clock edge
  initial begin
    logic [7:0] b;
    int st;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cyc;
        repeat (2) @(negedge clk);
        if (tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx;
        end
        repeat (4) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(b);
        start_q.push_back(st);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int i = 0;
    while (rx_q.size() < n && i < budget) begin step(); i++; end
    chk("rx_byte_count", rx_q.size(), n);
  endtask

  // Compare the first nw*5 received bytes with exp_w[0..nw-1]
  task automatic check_stream(input int nw, input string name);
    logic [39:0] s;
    logic [7:0]  a;
    for (int w = 0; w < nw; w++) begin
      s = exp_w[w];
      for (int k = 0; k < 5; k++) begin
        a = (5*w+k < rx_q.size()) ? rx_q[5*w+k] : 8'h00;
        chk(name, {24'h0, a}, {24'h0, s[39-8*k -: 8]});
      end
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 3000) begin step(); i++; end
    chk("busy_idle", busy, 1'b0);
    repeat (20) step();
  endtask

  // One word from an idle DUT: latency, busy timing and exact text
  task automatic run_word(input logic [15:0] w, input logic [39:0] s);
    int c0, n;
    rx_q.delete(); start_q.delete();
    dbg_in = w;
    step(); c0 = cyc;
    step(); n = 1;
    chk("busy_on", busy, 1'b1);
    while (busy && n < 400) begin step(); n++; end
    chk("busy_fall_cycle", n, 207);
    repeat (20) step();
    chk("rx_bytes", rx_q.size(), 5);
    chk("start_latency", (start_q.size() > 0) ? start_q[0] - c0 : -1, 3);
    chk("ovf_clear", overflow, 1'b0);
    exp_w[0] = s;
    check_stream(1, "word_text");
  endtask

  initial begin
    int bad_tx, bad_busy;
    vecs[0] = '{16'h0005, "0005\n"};
    vecs[1] = '{16'h12AF, "12AF\n"};
    vecs[2] = '{16'hFEDC, "FEDC\n"};
    vecs[3] = '{16'h9A0B, "9A0B\n"};
    vecs[4] = '{16'hF00D, "F00D\n"};

    rst_n = 1'b0; dbg_in = 16'h0000;
    repeat (3) step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    // Holding zero after reset is not a change
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("nochg_tx", bad_tx, 0);
    chk("nochg_busy", bad_busy, 0);

    for (int v = 0; v < 5; v++) run_word(vecs[v].word, vecs[v].str);

    // FIFO full while a new word arrives on the edge IDLE pops
    rx_q.delete(); start_q.delete();
    dbg_in = 16'h00A1; step();
    dbg_in = 16'h00A2; step();
    dbg_in = 16'h00A3; step();
    dbg_in = 16'h00A4; step();
    dbg_in = 16'h00A5; step();
    chk("full_no_ovf", overflow, 1'b0);
    repeat (202) step();
    dbg_in = 16'h00A6; step();
    chk("simul_no_ovf", overflow, 1'b0);
    wait_bytes(30, 2000);
    exp_w[0] = "00A1\n"; exp_w[1] = "00A2\n"; exp_w[2] = "00A3\n";
    exp_w[3] = "00A4\n"; exp_w[4] = "00A5\n"; exp_w[5] = "00A6\n";
    check_stream(6, "simul_text");
    wait_idle();
    chk("simul_no_extra", rx_q.size(), 30);
    chk("simul_ovf_end", overflow, 1'b0);

    // Eight changes in eight cycles: one in flight, four queued, three dropped
    rx_q.delete(); start_q.delete();
    for (int v = 1; v <= 8; v++) begin dbg_in = 16'(v); step(); end
    chk("ovf_set", overflow, 1'b1);
    wait_bytes(25, 1500);
    exp_w[0] = "0001\n"; exp_w[1] = "0002\n"; exp_w[2] = "0003\n";
    exp_w[3] = "0004\n"; exp_w[4] = "0005\n";
    check_stream(5, "ovf_text");
    wait_idle();
    chk("ovf_no_extra", rx_q.size(), 25);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset during bit 3 of the second character with a full FIFO
    dbg_in = 16'h1234; step();
    dbg_in = 16'h1111; step();
    dbg_in = 16'h2222; step();
    dbg_in = 16'h3333; step();
    dbg_in = 16'h4444; step();
    dbg_in = 16'h5555; step();
    chk("pre_rst_ovf", overflow, 1'b1);
    repeat (55) step();
    chk("pre_rst_tx", tx, 1'b0);
    rst_n = 1'b0; dbg_in = 16'h0000;
    step();
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("post_rst_tx", bad_tx, 0);
    chk("post_rst_empty", bad_busy, 0);
    run_word(16'h00FF, "00FF\n");

    chk("framing", frame_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dbg_uart_tx.md
# dbg_uart_tx

Debug-output serializer placed directly downstream of the CPU core's 16-bit `dbg_out` bus. It detects every change of the debug word and queues the new value in a small FIFO. Each queued word is transmitted as four uppercase hex ASCII characters plus a line feed on an 8N1 UART line. This gives the FPGA build a human-readable trace of CPU debug writes without a logic analyser.

## Interface
Parameters:
- `CLK_DIV`, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 16, number of queued debug words; must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `dbg_in`  in  16  debug word from the CPU `dbg_out`; synchronous to `clk`.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high while a frame is being sent or the FIFO is non-empty.
- `overflow`  out  1  sticky flag: at least one change was dropped because the FIFO was full.

## Operation
- Change detector:
  - Register `last`, 16 bits, reset to 0x0000.
  - On every edge where `dbg_in != last`: set `last <= dbg_in` and request a push of `dbg_in`.
  - Holding the same value produces no push.
  - A first value of 0x0000 after reset produces no push.
- FIFO:
  - Synchronous, `FIFO_DEPTH` entries, with wrap-around read and write pointers and a count of width log2(`FIFO_DEPTH`)+1.
  - Push when full and no pop in the same cycle: the word is dropped, `last` is still updated, and `overflow` is set to 1.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
  - Push and pop in the same cycle while not full: both are performed.
  - `overflow` clears only on reset.
- Transmit FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head word into `word_r`, set `char_idx=0`, and go to LOAD.
  - LOAD: form `byte_r` from `char_idx`:
    - Indices 0..3 take the nibble `word_r[15-4*idx -: 4]`.
    - Index 4 is 0x0A.
    - Nibble mapping: values 0..9 become 0x30+n; values 10..15 become 0x37+n, giving 'A'..'F'.
    - Then go to START.
  - START: drive `tx=0` for `CLK_DIV` cycles, then go to DATA with `bit_idx=0`.
  - DATA: drive `tx=byte_r[bit_idx]` (LSB first) for `CLK_DIV` cycles each. After bit 7, go to STOP.
  - STOP: drive `tx=1` for `CLK_DIV` cycles. Then:
    - If `char_idx==4`, go to IDLE.
    - Otherwise increment `char_idx` and go to LOAD.
- Frame output:
  - Each word produces 5 characters of 10 bits each, which is 50·`CLK_DIV` cycles of bit time.
  - `tx` is 1 in IDLE and LOAD.
  - `tx` is driven from a register, so it is glitch-free.
- `busy` = (state != IDLE) || (FIFO count != 0), registered.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `overflow`=0.
  - `last`=0x0000, FIFO empty, state IDLE.
  - All counters 0.
- Reset mid-frame: on the first edge with `rst_n`=0, `tx` returns to 1 and all queued and in-flight data is discarded.
- Latency, with an empty FIFO and the FSM in IDLE:
  - Edge E0 captures the change and writes the FIFO.
  - E1: IDLE pops.
  - E2: LOAD.
  - After E3, START holds, so `tx` is low from E3.
  - Push-to-start-bit latency is 3 cycles.
- Characters within one word go back-to-back, with one LOAD cycle of idle-high between each stop bit and the next start bit.
- Consecutive words: STOP → IDLE → LOAD → START adds 2 idle-high cycles.
- Bit counter: counts 0..`CLK_DIV`-1 and reloads on each bit boundary; no drift accumulates across bits.

## Structure
- Package `dbg_uart_pkg` holds:
  - The state enum (IDLE, LOAD, START, DATA, STOP).
  - Constants `ASCII_LF`=0x0A, `ASCII_0`=0x30, `ASCII_A_OFS`=0x37.
  - The nibble-to-ASCII function.
- Sub-module `dbg_fifo`: a generic synchronous FIFO parameterised on width and depth, exposing `full`, `empty`, `push`, `pop`, and data. The top level holds the change detector, the FSM and the bit timer.

## Test plan
All scenarios use `CLK_DIV`=4 and `FIFO_DEPTH`=4.
- Single word: `dbg_in`=0x12AF for one cycle, then held → `tx` carries bytes 0x31, 0x32, 0x41, 0x46, 0x0A, LSB first with correct start and stop bits. The first start bit appears 3 cycles after the capturing edge. `busy` falls after the last stop bit.
- No-change: hold `dbg_in` at 0x0000 from reset for 1000 cycles → `tx` stays 1, `busy` stays 0. Then hold 0x0005 → exactly one frame "0005\n".
- Overflow: toggle `dbg_in` through 0x0001..0x0008, one value per cycle, while the first frame is in flight → exactly 5 words are transmitted: 0x0001 in flight plus 4 queued (0x0002..0x0005). `overflow`=1 stays set through all frames.
- Full with simultaneous pop: fill the FIFO, then change `dbg_in` on the same edge IDLE pops → the new word is accepted, no overflow, and order is preserved.
- Reset mid-frame: assert `rst_n`=0 for one cycle during DATA of the second character → `tx`=1 on the next edge, FIFO empty, `busy`=0, `overflow`=0. Then 0x00FF → clean "00FF\n".
- Hex range: 0xFEDC followed by 0x9A0B → "FEDC\n9A0B\n", covering every nibble-boundary mapping.
